// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB requester / identity-register
//               subsystem: bus widths, requester state encoding and the
//               slave register offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Bus widths (data and address are both fixed at 32 bits)
    localparam int C_DATA_W = 32;
    localparam int C_ADDR_W = 32;

    // Requester FSM state encoding
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_SETUP  = 2'd1;
    localparam logic [1:0] C_ST_ACCESS = 2'd2;

    // Identity register byte offsets
    localparam logic [3:0] C_OFF_GROUP   = 4'h0;
    localparam logic [3:0] C_OFF_DATE    = 4'h4;
    localparam logic [3:0] C_OFF_SURNAME = 4'h8;
    localparam logic [3:0] C_OFF_NAME    = 4'hC;

    // The register window occupies only the lowest 16 bytes of the address map
    function automatic logic addr_in_window(input logic [C_ADDR_W-1:0] addr);
        return (addr[C_ADDR_W-1:4] == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_id_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_id_regs
// Description : Zero-wait-state APB slave holding four 32-bit identity
//               registers (group number, date, surname, name). Read data is
//               combinational; writes commit on the edge closing ACCESS.
//               Optional macro APB_PSLVERR_EN adds an error response for
//               accesses outside the register window.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_id_regs
    import apb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [C_ADDR_W-1:0] paddr,
    input  logic [C_DATA_W-1:0] pwdata,
    output logic [C_DATA_W-1:0] prdata,
    output logic                pready
`ifdef APB_PSLVERR_EN
    ,
    output logic                pslverr
`endif
);

    logic [C_DATA_W-1:0] r_group;
    logic [C_DATA_W-1:0] r_date;
    logic [C_DATA_W-1:0] r_surname;
    logic [C_DATA_W-1:0] r_name;

    logic       w_mapped;
    logic       w_wr_en;
    logic [1:0] w_sel;
    logic [1:0] w_unused_lsb;

    // Byte lanes within a word are not decoded
    assign w_unused_lsb = paddr[1:0];
    assign w_sel        = paddr[3:2];
    assign w_mapped     = addr_in_window(paddr);
    assign w_wr_en      = psel && penable && pwrite && w_mapped;

    // No wait states: the slave always completes in the first ACCESS cycle
    assign pready = psel && penable;

`ifdef APB_PSLVERR_EN
    // Flag any ACCESS cycle that falls outside the register window
    assign pslverr = psel && penable && !w_mapped;
`endif

    // Register file: full-word writes to the decoded register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_group   <= '0;
            r_date    <= '0;
            r_surname <= '0;
            r_name    <= '0;
        end else if (w_wr_en) begin
            case (w_sel)
                C_OFF_GROUP[3:2]:   r_group   <= pwdata;
                C_OFF_DATE[3:2]:    r_date    <= pwdata;
                C_OFF_SURNAME[3:2]: r_surname <= pwdata;
                default:            r_name    <= pwdata;
            endcase
        end
    end

    // Read mux: addressed register during a selected read, zero otherwise
    always_comb begin
        prdata = '0;
        if (psel && !pwrite && w_mapped) begin
            case (w_sel)
                C_OFF_GROUP[3:2]:   prdata = r_group;
                C_OFF_DATE[3:2]:    prdata = r_date;
                C_OFF_SURNAME[3:2]: prdata = r_surname;
                default:            prdata = r_name;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_slave
// Description : Free-running APB3 requester paired with the identity register
//               slave. The request port is sampled on every SETUP entry and
//               completed read data is returned on PRDATA_MASTER. Internal bus
//               signals are exported for observation.
//               Optional macro APB_PSLVERR_EN adds the PSLVERR output and
//               suppresses read capture on errored transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_slave
    import apb_pkg::*;
(
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PWRITE_MASTER,
    input  logic [C_ADDR_W-1:0] PADDR_MASTER,
    input  logic [C_DATA_W-1:0] PWDATA_MASTER,
    output logic [C_DATA_W-1:0] PRDATA_MASTER,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [C_ADDR_W-1:0] PADDR,
    output logic [C_DATA_W-1:0] PWDATA,
    output logic [C_DATA_W-1:0] PRDATA,
    output logic                PREADY
`ifdef APB_PSLVERR_EN
    ,
    output logic                PSLVERR
`endif
);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_pwrite;
    logic [C_ADDR_W-1:0] r_paddr;
    logic [C_DATA_W-1:0] r_pwdata;
    logic [C_DATA_W-1:0] r_prdata_master;

    logic                w_psel;
    logic                w_penable;
    logic                w_pready;
    logic [C_DATA_W-1:0] w_prdata;
    logic                w_enter_setup;
    logic                w_read_done;
    logic                w_slverr;

    // Next-state logic: IDLE -> SETUP -> ACCESS -> (SETUP when ready)
    always_comb begin
        w_next_state = C_ST_IDLE;
        case (r_state)
            C_ST_IDLE:   w_next_state = C_ST_SETUP;
            C_ST_SETUP:  w_next_state = C_ST_ACCESS;
            C_ST_ACCESS: w_next_state = w_pready ? C_ST_SETUP : C_ST_ACCESS;
            default:     w_next_state = C_ST_IDLE;
        endcase
    end

    assign w_psel        = (r_state == C_ST_SETUP) || (r_state == C_ST_ACCESS);
    assign w_penable     = (r_state == C_ST_ACCESS);
    assign w_enter_setup = (w_next_state == C_ST_SETUP);

`ifdef APB_PSLVERR_EN
    assign PSLVERR = w_slverr;
`else
    assign w_slverr = 1'b0;
`endif

    // Errored reads leave the previously returned data in place
    assign w_read_done = w_penable && w_pready && !r_pwrite && !w_slverr;

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture on SETUP entry; held stable through ACCESS
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_enter_setup) begin
            r_pwrite <= PWRITE_MASTER;
            r_paddr  <= PADDR_MASTER;
            r_pwdata <= PWDATA_MASTER;
        end
    end

    // Read data return register, updated only when a read completes
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_prdata_master <= '0;
        end else if (w_read_done) begin
            r_prdata_master <= w_prdata;
        end
    end

    apb_id_regs u_id_regs (
        .clk     (PCLK),
        .rst     (PRESET),
        .psel    (w_psel),
        .penable (w_penable),
        .pwrite  (r_pwrite),
        .paddr   (r_paddr),
        .pwdata  (r_pwdata),
        .prdata  (w_prdata),
        .pready  (w_pready)
`ifdef APB_PSLVERR_EN
        ,
        .pslverr (w_slverr)
`endif
    );

    assign PRDATA_MASTER = r_prdata_master;
    assign PSEL          = w_psel;
    assign PENABLE       = w_penable;
    assign PWRITE        = r_pwrite;
    assign PADDR         = r_paddr;
    assign PWDATA        = r_pwdata;
    assign PRDATA        = w_prdata;
    assign PREADY        = w_pready;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_slave
// Description : Directed self-checking bench for apb_master_slave. Transfers
//               are aligned to SETUP entry of the free-running requester;
//               expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_slave;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PWRITE_MASTER = 1'b0;
    logic [31:0] PADDR_MASTER = 32'h0;
    logic [31:0] PWDATA_MASTER = 32'h0;
    logic [31:0] PRDATA_MASTER;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
`ifdef APB_PSLVERR_EN
    logic        PSLVERR;
`endif

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_slave dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .PWRITE_MASTER (PWRITE_MASTER),
        .PADDR_MASTER  (PADDR_MASTER),
        .PWDATA_MASTER (PWDATA_MASTER),
        .PRDATA_MASTER (PRDATA_MASTER),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY)
`ifdef APB_PSLVERR_EN
        ,
        .PSLVERR       (PSLVERR)
`endif
    );

    // Wait (bounded) until the next rising edge will enter SETUP
    task automatic align_to_setup();
        int guard = 0;
        @(negedge PCLK);
        while (!(PSEL == 1'b0 || PENABLE == 1'b1) && guard < 8) begin
            @(negedge PCLK);
            guard++;
        end
        checks++;
        if (guard >= 8) begin
            errors++;
            $display("FAIL align_timeout: psel=%b penable=%b never reached SETUP entry", PSEL, PENABLE);
        end
    endtask

    // One transfer: drive request, sample ACCESS cycle and the data returned after it
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] acc_prdata, output logic acc_ok,
                            output logic acc_err, output logic [31:0] prm);
        align_to_setup();
        PWRITE_MASTER = wr;
        PADDR_MASTER  = addr;
        PWDATA_MASTER = data;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        acc_prdata = PRDATA;
        acc_ok = PSEL && PENABLE && PREADY && (PWRITE == wr) && (PADDR == addr)
                 && (!wr || PWDATA == data);
`ifdef APB_PSLVERR_EN
        acc_err = PSLVERR;
`else
        acc_err = 1'b0;
`endif
        @(posedge PCLK);
        #1;
        prm = PRDATA_MASTER;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE, PREADY} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got psel/en/wr/rdy=%b want 0000", {PSEL, PENABLE, PWRITE, PREADY});
        end
        checks++;
        if ({PADDR, PWDATA, PRDATA_MASTER} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h prm=%h want 0", PADDR, PWDATA, PRDATA_MASTER);
        end
        PRESET = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got psel=%b want 0", PSEL);
        end
        @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE} !== 2'b10) begin
            errors++;
            $display("FAIL first_setup: got psel/en=%b want 10", {PSEL, PENABLE});
        end
    endtask

    task automatic test_group();
        logic [31:0] d; logic ok; logic er; logic [31:0] prm;
        apb_xfer(1'b1, 32'h0, 32'd12, d, ok, er, prm);
        checks++;
        if (ok !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL group_write_access: got ok=%b prdata=%h want ok=1 prdata=0", ok, d);
        end
        apb_xfer(1'b0, 32'h0, 32'h0, d, ok, er, prm);
        checks++;
        if (ok !== 1'b1 || d !== 32'd12) begin
            errors++;
            $display("FAIL group_read_access: got ok=%b prdata=%h want ok=1 prdata=0000000c", ok, d);
        end
        checks++;
        if (prm !== 32'd12) begin
            errors++;
            $display("FAIL group_read: got %h want 0000000c", prm);
        end
    endtask

    task automatic test_date_name();
        logic [31:0] d; logic ok; logic er; logic [31:0] prm;
        apb_xfer(1'b1, 32'h4, 32'h01112023, d, ok, er, prm);
        // 32'h9711097115 truncated to the bus width
        apb_xfer(1'b1, 32'hC, 32'h11097115, d, ok, er, prm);
        apb_xfer(1'b0, 32'h4, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'h01112023) begin
            errors++;
            $display("FAIL date_read: got %h want 01112023", prm);
        end
        apb_xfer(1'b0, 32'hC, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'h11097115) begin
            errors++;
            $display("FAIL name_read: got %h want 11097115", prm);
        end
    endtask

    task automatic test_surname();
        logic [31:0] d; logic ok; logic er; logic [31:0] prm;
        // 32'h10711711497 truncated to the bus width
        apb_xfer(1'b1, 32'h8, 32'h11711497, d, ok, er, prm);
        apb_xfer(1'b0, 32'h8, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'h11711497) begin
            errors++;
            $display("FAIL surname_read: got %h want 11711497", prm);
        end
        // Byte-lane bits are ignored: 0x3 aliases the group register
        apb_xfer(1'b0, 32'h3, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'd12) begin
            errors++;
            $display("FAIL lane_ignore: got %h want 0000000c", prm);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic ok; logic er; logic [31:0] prm;
        apb_xfer(1'b0, 32'h8, 32'h0, d, ok, er, prm);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL mapped_noerr: got pslverr=%b want 0", er);
        end
        apb_xfer(1'b0, 32'h10, 32'h0, d, ok, er, prm);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_prdata: got %h want 00000000", d);
        end
`ifdef APB_PSLVERR_EN
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_pslverr: got %b want 1", er);
        end
        checks++;
        if (prm !== 32'h11711497) begin
            errors++;
            $display("FAIL unmapped_hold: got %h want 11711497", prm);
        end
`else
        checks++;
        if (prm !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h want 00000000", prm);
        end
`endif
        // Write outside the window must not alias onto the date register
        apb_xfer(1'b1, 32'h14, 32'hFFFF0000, d, ok, er, prm);
        apb_xfer(1'b0, 32'h4, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'h01112023) begin
            errors++;
            $display("FAIL unmapped_write: got date %h want 01112023", prm);
        end
    endtask

    task automatic test_inflight();
        logic [31:0] d; logic ok; logic er; logic [31:0] prm;
        apb_xfer(1'b1, 32'h8, 32'h0000A5A5, d, ok, er, prm);
        apb_xfer(1'b1, 32'hC, 32'h00005A5A, d, ok, er, prm);
        align_to_setup();
        PWRITE_MASTER = 1'b0;
        PADDR_MASTER  = 32'h8;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        PADDR_MASTER = 32'hC;
        #1;
        checks++;
        if (PADDR !== 32'h8 || PRDATA !== 32'h0000A5A5) begin
            errors++;
            $display("FAIL inflight_hold: got paddr=%h prdata=%h want 00000008 0000a5a5", PADDR, PRDATA);
        end
        @(posedge PCLK);
        #1;
        checks++;
        if (PRDATA_MASTER !== 32'h0000A5A5 || PADDR !== 32'hC || {PSEL, PENABLE} !== 2'b10) begin
            errors++;
            $display("FAIL inflight_next: got prm=%h paddr=%h psel/en=%b want 0000a5a5 0000000c 10",
                     PRDATA_MASTER, PADDR, {PSEL, PENABLE});
        end
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        checks++;
        if (PRDATA_MASTER !== 32'h00005A5A) begin
            errors++;
            $display("FAIL inflight_new_read: got %h want 00005a5a", PRDATA_MASTER);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic ok; logic er; logic [31:0] prm;
        align_to_setup();
        PWRITE_MASTER = 1'b1;
        PADDR_MASTER  = 32'h4;
        PWDATA_MASTER = 32'hDEADBEEF;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b111) begin
            errors++;
            $display("FAIL midreset_access: got psel/en/wr=%b want 111", {PSEL, PENABLE, PWRITE});
        end
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PREADY} !== 4'b0000 || {PADDR, PWDATA, PRDATA_MASTER, PRDATA} !== 128'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got ctrl=%b paddr=%h pwdata=%h prm=%h want all 0",
                     {PSEL, PENABLE, PWRITE, PREADY}, PADDR, PWDATA, PRDATA_MASTER);
        end
        PRESET = 1'b0;
        PWRITE_MASTER = 1'b0;
        apb_xfer(1'b0, 32'h4, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'h0) begin
            errors++;
            $display("FAIL midreset_date: got %h want 00000000", prm);
        end
        apb_xfer(1'b0, 32'h0, 32'h0, d, ok, er, prm);
        checks++;
        if (prm !== 32'h0) begin
            errors++;
            $display("FAIL midreset_group: got %h want 00000000", prm);
        end
    endtask

    initial begin
        test_reset();
        test_group();
        test_date_name();
        test_surname();
        test_unmapped();
        test_inflight();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
